axis_pingpong_buffer: RTL and testbench

//  Parametrised AXI-Stream packet buffer; generalises the fixed-depth DMA buffer stage.

---
 rtl/axis_buf_pkg.sv | 13 +
 rtl/axis_pingpong_buffer_sdp_ram.sv | 26 ++
 rtl/axis_pingpong_buffer.sv | 173 +++++++++++++++++
 tb/tb_axis_pingpong_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_buf_pkg.sv
// Shared definitions for the DMA-facing AXI-Stream buffer blocks.
package axis_buf_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned DEFAULT_MAX_WORDS  = 32;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axis_pingpong_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sdp_ram
  import axis_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(2 * DEFAULT_MAX_WORDS)
) (
  input  logic                  aclk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_pingpong_buffer.sv
// Ping-pong AXI-Stream packet buffer: ingest into one bank while the other replays.
module axis_pingpong_buffer
  import axis_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_WORDS  = DEFAULT_MAX_WORDS,
  parameter int unsigned ADDR_WIDTH = $clog2(MAX_WORDS),
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  err_len,
  output logic [1:0]            bank_full
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_WORDS);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  logic                 run_q;
  logic                 wr_bank;
  logic [LEN_WIDTH-1:0] wr_cnt;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] stored_len [2];

  rd_state_e            rd_state;
  logic                 rd_bank;
  logic [LEN_WIDTH-1:0] rd_addr;
  logic                 rd_vld_q;
  logic                 rd_last_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                 sk_valid;
  logic                 sk_last;
  logic [DATA_WIDTH-1:0] sk_data;

  logic                 wr_acc_c, len_hit_c, close_c;
  logic [LEN_WIDTH-1:0] cfg_eff_c, cur_len_c, wr_cnt_inc_c, rd_len_c;
  logic                 pop_c, free_c, rd_issue_c, rd_issue_last_c;
  logic [1:0]           occ_c, bank_set_c, bank_clr_c;

  // Ready only after reset has been released for one edge, and only into an empty bank.
  assign s_axis_tready = run_q & ~bank_full[wr_bank];

  always_comb begin
    wr_acc_c     = s_axis_tvalid & s_axis_tready;
    cfg_eff_c    = (cfg_len == '0 || cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    cur_len_c    = (wr_cnt == '0) ? cfg_eff_c : len_reg;
    wr_cnt_inc_c = wr_cnt + ONE;
    len_hit_c    = (wr_cnt_inc_c == cur_len_c);
    close_c      = wr_acc_c & (s_axis_tlast | len_hit_c);

    pop_c      = m_axis_tvalid & m_axis_tready;
    free_c     = pop_c & m_axis_tlast;
    rd_len_c   = stored_len[rd_bank];
    occ_c      = 2'(m_axis_tvalid) + 2'(sk_valid) + 2'(rd_vld_q);
    rd_issue_c = 1'b0;
    // Keep out + skid + in-flight RAM read within the two output slots.
    case (rd_state)
      RD_IDLE:             rd_issue_c = bank_full[rd_bank];
      RD_PRIME, RD_STREAM: rd_issue_c = (rd_addr < rd_len_c) && (occ_c <= 2'd1 + 2'(pop_c));
      default:             rd_issue_c = 1'b0;
    endcase
    rd_issue_last_c = (rd_addr == rd_len_c - ONE);

    bank_set_c = close_c ? (2'b01 << wr_bank) : 2'b00;
    bank_clr_c = free_c  ? (2'b01 << rd_bank) : 2'b00;
  end

  // Write side: word counter, per-packet length capture and close.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      run_q         <= 1'b0;
      wr_bank       <= 1'b0;
      wr_cnt        <= '0;
      len_reg       <= '0;
      err_len       <= 1'b0;
      stored_len[0] <= '0;
      stored_len[1] <= '0;
      bank_full     <= 2'b00;
    end else begin
      run_q     <= 1'b1;
      err_len   <= wr_acc_c & ~s_axis_tlast & len_hit_c;
      bank_full <= (bank_full | bank_set_c) & ~bank_clr_c;
      if (wr_acc_c) begin
        if (wr_cnt == '0) len_reg <= cfg_eff_c;
        if (close_c) begin
          stored_len[wr_bank] <= wr_cnt_inc_c;
          wr_bank             <= ~wr_bank;
          wr_cnt              <= '0;
        end else begin
          wr_cnt <= wr_cnt_inc_c;
        end
      end
    end
  end

  // Read side: replay FSM, RAM read pipeline and two-entry output skid.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state      <= RD_IDLE;
      rd_bank       <= 1'b0;
      rd_addr       <= '0;
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      sk_valid      <= 1'b0;
      sk_last       <= 1'b0;
      sk_data       <= '0;
    end else begin
      rd_vld_q <= rd_issue_c;
      if (rd_issue_c) begin
        rd_last_q <= rd_issue_last_c;
        rd_addr   <= rd_addr + ONE;
      end

      case (rd_state)
        RD_IDLE:   if (bank_full[rd_bank]) rd_state <= RD_PRIME;
        RD_PRIME:  rd_state <= RD_STREAM;
        RD_STREAM: begin
          if (free_c) begin
            rd_state <= RD_IDLE;
            rd_bank  <= ~rd_bank;
            rd_addr  <= '0;
          end
        end
        default:   rd_state <= RD_IDLE;
      endcase

      if (!m_axis_tvalid || pop_c) begin
        if (sk_valid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= sk_data;
          m_axis_tlast  <= sk_last;
          sk_valid      <= rd_vld_q;
          sk_data       <= ram_rdata;
          sk_last       <= rd_last_q;
        end else begin
          m_axis_tvalid <= rd_vld_q;
          m_axis_tlast  <= rd_vld_q & rd_last_q;
          if (rd_vld_q) m_axis_tdata <= ram_rdata;
        end
      end else if (rd_vld_q) begin
        sk_valid <= 1'b1;
        sk_data  <= ram_rdata;
        sk_last  <= rd_last_q;
      end
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_ram (
    .aclk  (aclk),
    .we    (wr_acc_c),
    .waddr ({wr_bank, wr_cnt[ADDR_WIDTH-1:0]}),
    .wdata (s_axis_tdata),
    .re    (rd_issue_c),
    .raddr ({rd_bank, rd_addr[ADDR_WIDTH-1:0]}),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axis_pingpong_buffer.sv
// Scoreboard bench for axis_pingpong_buffer: directed packets, back-pressure, random traffic, reset.
module tb_axis_pingpong_buffer;

  localparam int unsigned DW = 64;
  localparam int unsigned LW = 6;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic          err_len;
  logic [1:0]    bank_full;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0, n_err = 0, err_seen = 0, exp_err = 0;
  logic rnd_ready = 1'b0, fix_ready = 1'b0;
  logic prev_stall = 1'b0, prev_last;
  logic [DW-1:0] prev_data;

  always #5 aclk = ~aclk;

  axis_pingpong_buffer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_len       (cfg_len),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .err_len       (err_len),
    .bank_full     (bank_full)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output sink: fixed or random ready, updated just after each rising edge.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #2;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
    end
  end

  // Monitor: handshakes decided at the next rising edge are checked on the falling edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", 64'(m_tlast), 64'(prev_last));
      end
      if (err_len) err_seen++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h, expected no output (t=%0t)", m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.data);
          chk("out_last", 64'(m_tlast), 64'(e.last));
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last, input logic exp_last);
    int t = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    do begin
      @(negedge aclk);
      t++;
    end while (!s_tready && t < 2000);
    if (!s_tready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: s_axis_tready stayed 0, expected 1 within 2000 cycles");
    end else begin
      exp_q.push_back(exp_t'{last: exp_last, data: d});
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      @(posedge aclk);
      t++;
    end
    repeat (4) @(posedge aclk);
    #1;
    chk({name, "_outstanding"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_err_len_count"}, 64'(err_seen), 64'(exp_err));
    exp_q.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    aresetn  = 1'b0;
    cfg_len  = '0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    // Reset values
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_bank_full", 64'(bank_full), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("release_s_tready", 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1;

    // 1: exact-length packet with tlast, plus first-word latency
    fix_ready = 1'b1;
    cfg_len = LW'(21);
    for (int i = 1; i <= 21; i++) send(64'h0100_0000 + 64'(i), i == 21, i == 21);
    @(negedge aclk);
    chk("t1_lat_edge0", 64'(m_tvalid), 64'd0);
    @(negedge aclk);
    chk("t1_lat_edge1", 64'(m_tvalid), 64'd0);
    @(negedge aclk);
    chk("t1_lat_edge2", 64'(m_tvalid), 64'd1);
    drain("t1");

    // 2: early tlast, then a full-length packet
    cfg_len = LW'(8);
    for (int i = 1; i <= 5; i++) send(64'h0200_0000 + 64'(i), i == 5, i == 5);
    for (int i = 1; i <= 8; i++) send(64'h0210_0000 + 64'(i), i == 8, i == 8);
    drain("t2");

    // 3: length close without tlast, remainder forms a 2-word packet
    cfg_len = LW'(4);
    for (int i = 1; i <= 6; i++) send(64'h0300_0000 + 64'(i), i == 6, i == 4 || i == 6);
    exp_err++;
    drain("t3");

    // 4: both banks fill under back-pressure, then release
    fix_ready = 1'b0;
    cfg_len = LW'(32);
    for (int p = 0; p < 2; p++)
      for (int i = 1; i <= 32; i++) send(64'h0400_0000 + 64'(p * 256 + i), i == 32, i == 32);
    @(negedge aclk);
    chk("t4_full_s_tready", 64'(s_tready), 64'd0);
    chk("t4_bank_full", 64'(bank_full), 64'd3);
    @(posedge aclk);
    #1;
    fix_ready = 1'b1;
    begin
      int t = 0;
      do begin
        @(negedge aclk);
        t++;
      end while (!(m_tvalid && m_tready && m_tlast) && t < 500);
      chk("t4_first_last_seen", 64'(m_tvalid && m_tready && m_tlast), 64'd1);
      chk("t4_s_tready_before_free", 64'(s_tready), 64'd0);
      @(negedge aclk);
      chk("t4_s_tready_after_free", 64'(s_tready), 64'd1);
      @(posedge aclk);
      #1;
    end
    for (int i = 1; i <= 32; i++) send(64'h0400_0000 + 64'(2 * 256 + i), i == 32, i == 32);
    drain("t4");

    // 5: random lengths, cfg changes mid-packet, random gaps and ready
    rnd_ready = 1'b1;
    for (int p = 0; p < 600; p++) begin
      int unsigned cfg, eff, n;
      logic notl;
      cfg  = $urandom_range(0, 40);
      eff  = (cfg == 0 || cfg > 32) ? 32 : cfg;
      n    = $urandom_range(1, eff);
      notl = (n == eff) && ($urandom_range(0, 1) == 1);
      cfg_len = LW'(cfg);
      for (int unsigned i = 1; i <= n; i++) begin
        send({32'(p), 32'(i)}, (i == n) && !notl, i == n);
        if (i == 1) cfg_len = LW'($urandom_range(0, 40));
        idle($urandom_range(0, 2));
      end
      if (notl) exp_err++;
    end
    drain("t5");
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    idle(2);

    // 6: reset during replay, then a fresh packet
    cfg_len = LW'(16);
    for (int i = 1; i <= 16; i++) send(64'h0600_0000 + 64'(i), i == 16, i == 16);
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    chk("t6_replaying", 64'(m_tvalid), 64'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("t6_rst_m_tdata", m_tdata, 64'd0);
    chk("t6_rst_bank_full", 64'(bank_full), 64'd0);
    chk("t6_rst_s_tready", 64'(s_tready), 64'd0);
    chk("t6_rst_err_len", 64'(err_len), 64'd0);
    @(posedge aclk);
    #1;
    cfg_len = LW'(3);
    for (int i = 1; i <= 3; i++) send(64'h0700_0000 + 64'(i), i == 3, i == 3);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
